// File: rtl/square_synth_mixer_pkg.sv
// Shared constants and helpers for the square/pulse synthesiser voices and mixer.
package synth_pkg;

  typedef enum logic {
    DUTY_SQUARE  = 1'b0,
    DUTY_PULSE25 = 1'b1
  } duty_e;

  localparam logic [2:0] DECAY_HOLD = 3'd0;

  // Mix width wide enough for NUM_CH full-scale voices without saturation.
  function automatic int mix_width(input int num_ch, input int vol_w);
    return vol_w + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/square_synth_mixer_voice.sv
// One synthesiser voice: phase accumulator, square/pulse bit select and decay envelope.
module synth_voice
  import synth_pkg::*;
#(
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned INC_W   = 8,
  parameter int unsigned OCT_W   = 2,
  parameter int unsigned VOL_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_stb,
  input  logic               tick_stb,
  input  logic [INC_W-1:0]   note_inc,
  input  logic [OCT_W-1:0]   note_oct,
  input  logic               duty,
  input  logic [2:0]         decay_sh,
  input  logic               trig,
  output logic [VOL_W-1:0]   smp,
  output logic [VOL_W-1:0]   vol
);

  localparam int unsigned PIDX_W = (PHASE_W > 1) ? $clog2(PHASE_W) : 1;

  logic [PHASE_W-1:0] pha_q, pha_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic [PIDX_W-1:0]  hi_idx, lo_idx;
  logic               on;

  always_comb begin
    pha_d = pha_q;
    if (sample_stb) begin
      pha_d = pha_q + PHASE_W'(note_inc);
    end
  end

  // Octave shifts the observed phase bit down; the pulse companion bit clamps at 0.
  always_comb begin
    hi_idx = PIDX_W'(PHASE_W - 1) - PIDX_W'(note_oct);
    lo_idx = (hi_idx == '0) ? '0 : hi_idx - PIDX_W'(1);
    on     = pha_q[hi_idx];
    if (duty == DUTY_PULSE25) begin
      on = pha_q[hi_idx] & pha_q[lo_idx];
    end
  end

  // Trigger beats decay; decay stalls at the floor where vol >> sh reaches zero.
  always_comb begin
    vol_d = vol_q;
    if (trig) begin
      vol_d = '1;
    end else if (tick_stb && (decay_sh != DECAY_HOLD)) begin
      vol_d = vol_q - (vol_q >> decay_sh);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pha_q <= '0;
      vol_q <= '0;
    end else begin
      pha_q <= pha_d;
      vol_q <= vol_d;
    end
  end

  assign smp = on ? vol_q : '0;
  assign vol = vol_q;

endmodule

// File: rtl/square_synth_mixer.sv
// N-voice square/pulse synthesiser: voices, registered mixer and first-order PWM output.
module square_synth_mixer
  import synth_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned INC_W   = 8,
  parameter int unsigned OCT_W   = 2,
  parameter int unsigned VOL_W   = 6,
  localparam int unsigned S_W    = mix_width(NUM_CH, VOL_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_stb,
  input  logic                      tick_stb,
  input  logic [NUM_CH*INC_W-1:0]   note_inc,
  input  logic [NUM_CH*OCT_W-1:0]   note_oct,
  input  logic [NUM_CH-1:0]         duty,
  input  logic [NUM_CH*3-1:0]       decay_sh,
  input  logic [NUM_CH-1:0]         trig,
  output logic [S_W-1:0]            mix_out,
  output logic                      pwm_out,
  output logic [NUM_CH*VOL_W-1:0]   vol_out
);

  logic [VOL_W-1:0] smp [NUM_CH];
  logic [VOL_W-1:0] vol [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_voice
    synth_voice #(
      .PHASE_W (PHASE_W),
      .INC_W   (INC_W),
      .OCT_W   (OCT_W),
      .VOL_W   (VOL_W)
    ) u_voice (
      .clk        (clk),
      .reset      (reset),
      .sample_stb (sample_stb),
      .tick_stb   (tick_stb),
      .note_inc   (note_inc[k*INC_W +: INC_W]),
      .note_oct   (note_oct[k*OCT_W +: OCT_W]),
      .duty       (duty[k]),
      .decay_sh   (decay_sh[k*3 +: 3]),
      .trig       (trig[k]),
      .smp        (smp[k]),
      .vol        (vol[k])
    );
    assign vol_out[k*VOL_W +: VOL_W] = vol[k];
  end

  logic [S_W-1:0] mix_q, mix_d;
  logic [S_W-1:0] acc_q, acc_d;
  logic           pwm_q, pwm_d;
  logic [S_W:0]   acc_next;

  always_comb begin
    mix_d = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      mix_d = mix_d + S_W'(smp[k]);
    end
  end

  // First-order sigma-delta: the carry out of the accumulator is the PWM bit.
  always_comb begin
    acc_next = {1'b0, acc_q} + {1'b0, mix_q};
    acc_d    = acc_next[S_W-1:0];
    pwm_d    = acc_next[S_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_q <= '0;
      acc_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      mix_q <= mix_d;
      acc_q <= acc_d;
      pwm_q <= pwm_d;
    end
  end

  assign mix_out = mix_q;
  assign pwm_out = pwm_q;

endmodule

// File: doc/square_synth_mixer.md
# square_synth_mixer

Parametrised N-voice square/pulse synthesiser with per-voice decay envelopes, a registered mixer and a first-order PWM output. It is the next-generation audio back-end for the demo tops. A sequencer drives it with per-voice note increments, octaves and triggers. All state runs in the pixel-clock domain; sample and tick rates come from single-cycle strobes, not from derived clocks. `pwm_out` drives an audio pin directly.

## Interface
Parameters:
- `NUM_CH`, 2, number of voices (1..8)
- `PHASE_W`, 16, phase accumulator width per voice
- `INC_W`, 8, note increment width (INC_W ≤ PHASE_W)
- `OCT_W`, 2, octave select width (2^OCT_W ≤ PHASE_W)
- `VOL_W`, 6, envelope/volume width
- `S_W`, derived, `VOL_W + $clog2(NUM_CH)` (min `VOL_W`), mix width

Ports:
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `sample_stb`  in  1  one-cycle pulse; advance all phases
- `tick_stb`  in  1  one-cycle pulse; apply envelope decay
- `note_inc`  in  NUM_CH*INC_W  per-voice phase increment, voice k at `[k*INC_W +: INC_W]`
- `note_oct`  in  NUM_CH*OCT_W  per-voice octave
- `duty`  in  NUM_CH  per-voice waveform: 0 = 50 % square, 1 = 25 % pulse
- `decay_sh`  in  NUM_CH*3  per-voice decay shift; 0 = hold (no decay)
- `trig`  in  NUM_CH  one-cycle pulse; retrigger voice envelope to full scale
- `mix_out`  out  S_W  registered sum of voice samples
- `pwm_out`  out  1  registered PWM bit
- `vol_out`  out  NUM_CH*VOL_W  current envelope per voice (debug and visualiser)

## Operation
- **Phase.** On `sample_stb`, `pha[k] <= pha[k] + zero_ext(note_inc[k])`, modulo 2^PHASE_W. The phase is never reset by a trigger.
- **Waveform bit.** Let `b = PHASE_W-1-note_oct[k]`.
  - duty 0: `on = pha[b]`
  - duty 1: `on = pha[b] & pha[b-1]`
  - `b-1` is clamped to ≥0.
- **Voice sample.** `smp[k] = on ? vol[k] : 0`.
- **Envelope, per voice, priority order:**
  1. `trig[k]`: `vol <= 2^VOL_W-1`
  2. else `tick_stb` and `decay_sh != 0`: `vol <= vol - (vol >> decay_sh)`
  3. else hold
- Decay is monotonic and bottoms out at a small nonzero floor (`vol >> sh == 0`). This is intentional and matches the existing voice sound.
- **Mixer.** `mix_out <= Σ smp[k]` every cycle, S_W wide, no saturation needed (max `NUM_CH*(2^VOL_W-1)` fits).
- **PWM.**
  - `acc_next = {1'b0,acc} + mix_out` (S_W+1 bits)
  - `acc <= acc_next[S_W-1:0]`
  - `pwm_out <= acc_next[S_W]`
  - Mean duty = `mix_out / 2^S_W`.
- Strobes may coincide. `sample_stb` and `tick_stb` together are both applied in the same cycle, each from pre-edge state.

## Timing
- **Reset values:**
  - `pha = 0`, `vol = 0`, `acc = 0`
  - `mix_out = 0`, `pwm_out = 0`, `vol_out = 0`
- Reset is asynchronous and takes effect mid-operation immediately. The first update happens on the first `clk` edge after deassertion.
- **Latencies:**
  - `sample_stb`/`trig` at edge n: `pha`/`vol` updated at n+1.
  - `mix_out` reflects that update at n+2.
  - `pwm_out` reflects the new `mix_out` at n+3.
- `vol_out` is the `vol` register (latency 1).
- Strobes must be single-cycle. A strobe held high for m cycles acts m times; this is not an error.
- `note_inc`, `note_oct`, `duty` and `decay_sh` are sampled combinationally on the strobe edge. No hold requirement beyond that edge.

## Structure
- Package `synth_pkg`:
  - `DUTY_SQUARE=1'b0`, `DUTY_PULSE25=1'b1`
  - `DECAY_HOLD=3'd0`
  - `function mix_width(num_ch, vol_w)`
- Sub-module `synth_voice`: one phase accumulator, waveform-bit select, envelope; outputs `smp` and `vol`.
- Top generates `NUM_CH` instances, then the adder tree, mix register and PWM accumulator.

## Test plan
- **Reset and idle.** Assert `reset` mid-run with a voice at vol 63 → all outputs 0 asynchronously. After release with no trig, `pwm_out` stays 0 for 1000 cycles.
- **Trigger and decay.** NUM_CH=2, VOL_W=6, `trig[0]` → `vol_out[0]=63`. Then 3 `tick_stb` with `decay_sh=3` → 56, 49, 43. With `decay_sh=0` → stays 63.
- **Trig vs tick priority.** `trig[1]` and `tick_stb` in the same cycle (`decay_sh=2`) → `vol[1]=63`, not 48.
- **Pitch and octave.** `note_inc=0x80`, `note_oct=0`, PHASE_W=16, a sample_stb every cycle → square bit toggles every 256 strobes. `note_oct=3` → toggles every 32 strobes. `duty=1` → high 1/4 of each period.
- **Mixing and PWM duty.** Both voices held at vol 63, `on=1` → `mix_out=126`. Over 128 cycles, `pwm_out` is high exactly 126 times. Single voice at 32 → 32 of 128.
- **Wrap and coincident strobes.** `pha=0xFFF0`, `inc=0x20`, `sample_stb`+`tick_stb` together → `pha=0x0010`, and the decay is also applied that cycle.
